// File: rtl/gtxe2_chnl_tx_oob_pkg.sv
// Shared definitions for the GTXE2 channel OOB logic: FSM state encoding and
// default SATA OOB timing, common to the TX generator and the RX detector.
package gtxe2_chnl_tx_oob_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_BURST = 2'd1,
    S_GAP   = 2'd2
  } oob_state_e;

  // Lengths in serial_clk cycles at 1.5 Gb/s.
  localparam int unsigned SATA_BURST_LEN          = 160;
  localparam int unsigned SATA_GAP_LEN_INIT       = 480;
  localparam int unsigned SATA_GAP_LEN_WAKE       = 160;
  localparam int unsigned SATA_BURST_SEQ_LEN_DFLT = 6;

  function automatic int unsigned max3(input int unsigned a,
                                       input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/gtxe2_chnl_tx_oob_if.sv
// Line-side and control signals of the TX OOB generator.
// Inputs are levels sampled on the serial clock edge; there is no handshake,
// TXCOMFINISH is a single-cycle completion strobe.
interface gtxe2_chnl_tx_oob_if;
  import gtxe2_chnl_tx_oob_pkg::*;

  logic       TXCOMINIT;
  logic       TXCOMWAKE;
  logic       TXELECIDLE;
  logic       indata_ser;
  logic       TXP;
  logic       TXN;
  logic       TXCOMFINISH;
  logic       oob_active;
  oob_state_e state_dbg;

  modport slave (
    input  TXCOMINIT, TXCOMWAKE, TXELECIDLE, indata_ser,
    output TXP, TXN, TXCOMFINISH, oob_active, state_dbg
  );

  modport master (
    output TXCOMINIT, TXCOMWAKE, TXELECIDLE, indata_ser,
    input  TXP, TXN, TXCOMFINISH, oob_active, state_dbg
  );

endinterface

// File: rtl/gtxe2_chnl_tx_oob.sv
// TX OOB burst generator and line driver: emits COMINIT/COMWAKE burst/gap
// sequences, otherwise drives electrical idle or passes serial data through.
module gtxe2_chnl_tx_oob
  import gtxe2_chnl_tx_oob_pkg::*;
#(
  parameter int unsigned BURST_LEN          = SATA_BURST_LEN,
  parameter int unsigned GAP_LEN_INIT       = SATA_GAP_LEN_INIT,
  parameter int unsigned GAP_LEN_WAKE       = SATA_GAP_LEN_WAKE,
  parameter int unsigned SATA_BURST_SEQ_LEN = SATA_BURST_SEQ_LEN_DFLT
) (
  input logic                clk,
  input logic                rst_n,
  gtxe2_chnl_tx_oob_if.slave oob
);

  localparam int unsigned CW = $clog2(max3(BURST_LEN, GAP_LEN_INIT, GAP_LEN_WAKE) + 1);

  localparam logic [CW-1:0] BURST_RELOAD = CW'(BURST_LEN);
  localparam logic [CW-1:0] GAP_INIT_RL  = CW'(GAP_LEN_INIT);
  localparam logic [CW-1:0] GAP_WAKE_RL  = CW'(GAP_LEN_WAKE);
  localparam logic [3:0]    SEQ_LEN      = 4'(SATA_BURST_SEQ_LEN);

  oob_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    burst_q, burst_d;
  logic          toggle_q, toggle_d;
  logic          init_q, init_d;
  logic          finish_q, finish_d;

  logic [CW-1:0] gap_len;
  logic          req;
  logic          cnt_legal;
  logic          txp, txn;

  assign gap_len = init_q ? GAP_INIT_RL : GAP_WAKE_RL;
  assign req     = oob.TXCOMINIT | oob.TXCOMWAKE;

  // Out-of-range counters can only come from corruption; they force S_IDLE.
  always_comb begin
    cnt_legal = 1'b1;
    if (state_q == S_BURST) begin
      cnt_legal = (cnt_q != '0) && (cnt_q <= BURST_RELOAD) &&
                  (burst_q != 4'd0) && (burst_q <= SEQ_LEN);
    end else if (state_q == S_GAP) begin
      cnt_legal = (cnt_q != '0) && (cnt_q <= gap_len) &&
                  (burst_q != 4'd0) && (burst_q <= SEQ_LEN);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      burst_q  <= 4'd0;
      toggle_q <= 1'b0;
      init_q   <= 1'b0;
      finish_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      burst_q  <= burst_d;
      toggle_q <= toggle_d;
      init_q   <= init_d;
      finish_q <= finish_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    burst_d  = burst_q;
    toggle_d = toggle_q;
    init_d   = init_q;
    finish_d = 1'b0;

    if (state_q != S_IDLE && (!oob.TXELECIDLE || !cnt_legal)) begin
      // Abort: back to idle without a completion strobe.
      state_d  = S_IDLE;
      cnt_d    = '0;
      burst_d  = 4'd0;
      toggle_d = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (oob.TXELECIDLE && req) begin
            state_d  = S_BURST;
            cnt_d    = BURST_RELOAD;
            burst_d  = 4'd1;
            toggle_d = 1'b1;
            init_d   = oob.TXCOMINIT;
          end
        end
        S_BURST: begin
          if (cnt_q == CW'(1)) begin
            state_d  = S_GAP;
            cnt_d    = gap_len;
            toggle_d = 1'b0;
          end else begin
            cnt_d    = cnt_q - CW'(1);
            toggle_d = ~toggle_q;
          end
        end
        S_GAP: begin
          if (cnt_q != CW'(1)) begin
            cnt_d = cnt_q - CW'(1);
          end else if (burst_q < SEQ_LEN) begin
            state_d  = S_BURST;
            cnt_d    = BURST_RELOAD;
            burst_d  = burst_q + 4'd1;
            toggle_d = 1'b1;
          end else begin
            state_d  = S_IDLE;
            cnt_d    = '0;
            burst_d  = 4'd0;
            finish_d = 1'b1;
          end
        end
        default: begin
          state_d  = S_IDLE;
          cnt_d    = '0;
          burst_d  = 4'd0;
          toggle_d = 1'b0;
        end
      endcase
    end
  end

  // Line mux; reset forces electrical idle even when data would pass through.
  always_comb begin
    txp = 1'b0;
    txn = 1'b0;
    if (rst_n) begin
      if (state_q == S_BURST) begin
        txp = toggle_q;
        txn = ~toggle_q;
      end else if (state_q == S_IDLE && !oob.TXELECIDLE) begin
        txp = oob.indata_ser;
        txn = ~oob.indata_ser;
      end
    end
  end

  assign oob.TXP         = txp;
  assign oob.TXN         = txn;
  assign oob.TXCOMFINISH = finish_q;
  assign oob.oob_active  = (state_q != S_IDLE);
  assign oob.state_dbg   = state_q;

endmodule
